// File: rtl/exe_muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one valid/ready-handshaked FSM, with flush support for pipeline redirects.
module exe_muldiv_unit #(
  parameter int XLEN   = 64,
  parameter int UNROLL = 1,
  parameter int TAG_W  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [2:0]       i_op,
  input  logic             i_w,
  input  logic [XLEN-1:0]  i_op1,
  input  logic [XLEN-1:0]  i_op2,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_tag
);

  localparam int HALF  = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN / UNROLL + 1);
  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHU = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  function automatic logic signedA(input logic [2:0] op);
    return op[2] ? !op[0] : (op != OP_MULHU);
  endfunction

  function automatic logic signedB(input logic [2:0] op);
    return op[2] ? !op[0] : (op == OP_MUL || op == OP_MULH);
  endfunction

  function automatic logic [XLEN-1:0] extOperand(input logic [XLEN-1:0] v, input logic w,
                                                 input logic s);
    if (!w) return v;
    return {{HALF{s & v[HALF-1]}}, v[HALF-1:0]};
  endfunction

  state_t              r_state;
  logic                r_inReady, r_outValid, r_setup, r_special, r_w;
  logic                r_negRes, r_negRem;
  logic [2:0]          r_op;
  logic [CNT_W-1:0]    r_count;
  logic [XLEN-1:0]     r_a, r_b, r_mplr, r_quo, r_div, r_result;
  logic [XLEN:0]       r_rem;
  logic [2*XLEN-1:0]   r_acc, r_mcand;
  logic [TAG_W-1:0]    r_tag;

  logic                w_acceptW, w_negA, w_negB, w_divZero, w_ovf;
  logic [XLEN-1:0]     w_magA, w_magB, w_minNeg;
  logic [2*XLEN-1:0]   w_nextAcc, w_nextMcand, w_prod;
  logic [XLEN-1:0]     w_nextMplr, w_nextQuo, w_quoSrc, w_remSrc, w_quoFix, w_remFix;
  logic [XLEN-1:0]     w_raw, w_final;
  logic [XLEN:0]       w_nextRem;

  // High-half multiplies ignore the W flag and always run full width.
  assign w_acceptW = i_w && (i_op[2] || i_op == OP_MUL);

  assign w_negA    = signedA(r_op) & r_a[XLEN-1];
  assign w_negB    = signedB(r_op) & r_b[XLEN-1];
  assign w_magA    = w_negA ? -r_a : r_a;
  assign w_magB    = w_negB ? -r_b : r_b;
  assign w_minNeg  = r_w ? {{HALF{1'b1}}, 1'b1, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign w_divZero = (r_b == '0);
  assign w_ovf     = signedA(r_op) && (r_a == w_minNeg) && (r_b == '1);

  always_comb begin
    w_nextAcc   = r_acc;
    w_nextMcand = r_mcand;
    w_nextMplr  = r_mplr;
    w_nextQuo   = r_quo;
    w_nextRem   = r_rem;
    for (int i = 0; i < UNROLL; i++) begin
      if (w_nextMplr[0]) w_nextAcc = w_nextAcc + w_nextMcand;
      w_nextMcand = w_nextMcand << 1;
      w_nextMplr  = w_nextMplr >> 1;
      w_nextRem   = {w_nextRem[XLEN-1:0], w_nextQuo[XLEN-1]};
      w_nextQuo   = w_nextQuo << 1;
      if (w_nextRem >= {1'b0, r_div}) begin
        w_nextRem    = w_nextRem - {1'b0, r_div};
        w_nextQuo[0] = 1'b1;
      end
    end
  end

  // Special-case divides carry their answer in r_quo/r_rem and skip iterating.
  always_comb begin
    w_quoSrc = r_special ? r_quo : w_nextQuo;
    w_remSrc = r_special ? r_rem[XLEN-1:0] : w_nextRem[XLEN-1:0];
    w_prod   = r_negRes ? -w_nextAcc : w_nextAcc;
    w_quoFix = r_negRes ? -w_quoSrc : w_quoSrc;
    w_remFix = r_negRem ? -w_remSrc : w_remSrc;
    case (r_op)
      3'd0:       w_raw = w_prod[XLEN-1:0];
      3'd4, 3'd5: w_raw = w_quoFix;
      3'd6, 3'd7: w_raw = w_remFix;
      default:    w_raw = w_prod[2*XLEN-1:XLEN];
    endcase
    w_final = r_w ? {{HALF{w_raw[HALF-1]}}, w_raw[HALF-1:0]} : w_raw;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE; r_inReady <= 1'b1; r_outValid <= 1'b0;
      r_result <= '0; r_tag <= '0; r_count <= '0; r_setup <= 1'b0; r_special <= 1'b0;
    end else if (i_flush) begin
      r_state <= S_IDLE; r_inReady <= 1'b1; r_outValid <= 1'b0;
      r_count <= '0; r_setup <= 1'b0; r_special <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_in_valid) begin
          r_op      <= i_op;
          r_w       <= w_acceptW;
          r_a       <= extOperand(i_op1, w_acceptW, signedA(i_op));
          r_b       <= extOperand(i_op2, w_acceptW, signedB(i_op));
          r_tag     <= i_tag;
          r_setup   <= 1'b1;
          r_inReady <= 1'b0;
          r_state   <= S_CALC;
        end
        S_CALC: if (r_setup) begin
          r_setup   <= 1'b0;
          r_acc     <= '0;
          r_mcand   <= {{XLEN{1'b0}}, w_magA};
          r_mplr    <= w_magB;
          r_div     <= w_magB;
          r_special <= r_op[2] && (w_divZero || w_ovf);
          if (r_op[2] && w_divZero) begin
            r_quo <= '1; r_rem <= {1'b0, r_a}; r_negRes <= 1'b0; r_negRem <= 1'b0;
            r_count <= '0;
          end else if (r_op[2] && w_ovf) begin
            r_quo <= r_a; r_rem <= '0; r_negRes <= 1'b0; r_negRem <= 1'b0;
            r_count <= '0;
          end else begin
            r_quo    <= r_w ? (w_magA << HALF) : w_magA;
            r_rem    <= '0;
            r_negRes <= w_negA ^ w_negB;
            r_negRem <= w_negA;
            r_count  <= r_w ? CNT_W'(HALF / UNROLL) : CNT_W'(XLEN / UNROLL);
          end
        end else begin
          r_acc   <= w_nextAcc;
          r_mcand <= w_nextMcand;
          r_mplr  <= w_nextMplr;
          r_quo   <= w_nextQuo;
          r_rem   <= w_nextRem;
          if (!r_special) r_count <= r_count - 1'b1;
          if (r_special || r_count == CNT_W'(1)) begin
            r_result   <= w_final;
            r_outValid <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: if (i_out_ready) begin
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = r_inReady;
  assign o_out_valid = r_outValid;
  assign o_result    = r_result;
  assign o_tag       = r_tag;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Self-checking bench for exe_muldiv_unit: directed vector table, handshake/flush/reset
// sequences, and randomized operations checked against an arithmetic reference model.
module tb_exe_muldiv_unit;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, flush, inValid, inReady, w, outValid, outReady;
  logic [2:0]  op;
  logic [63:0] op1, op2, result;
  logic [4:0]  tagIn, tagOut;

  int errors = 0;
  int checks = 0;

  exe_muldiv_unit #(.XLEN(64), .UNROLL(1), .TAG_W(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(inValid), .o_in_ready(inReady),
    .i_op(op), .i_w(w), .i_op1(op1), .i_op2(op2), .i_tag(tagIn),
    .o_out_valid(outValid), .i_out_ready(outReady), .o_result(result), .o_tag(tagOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic effectiveW(input logic [2:0] o, input logic wf);
    return wf && (o == OP_MUL || o[2]);
  endfunction

  // Reference result built from plain wide arithmetic and the RV64M corner-case rules.
  function automatic logic [63:0] refModel(input logic [2:0] o, input logic wf,
                                          input logic [63:0] a, input logic [63:0] b);
    logic              ew;
    logic [127:0]      sa, sb, za, zb, p;
    longint            sA, sB;
    longint unsigned   uA, uB;
    logic [63:0]       r;
    ew = effectiveW(o, wf);
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    za = {64'd0, a};
    zb = {64'd0, b};
    if (ew) begin
      sA = longint'($signed(a[31:0]));
      sB = longint'($signed(b[31:0]));
      uA = {32'd0, a[31:0]};
      uB = {32'd0, b[31:0]};
    end else begin
      sA = a; sB = b; uA = a; uB = b;
    end
    r = '0;
    case (o)
      OP_MUL:    r = a * b;
      OP_MULH:   begin p = sa * sb; r = p[127:64]; end
      OP_MULHSU: begin p = sa * zb; r = p[127:64]; end
      OP_MULHU:  begin p = za * zb; r = p[127:64]; end
      OP_DIV:  if (sB == 0) r = ONES;
               else if (!ew && a == 64'h8000_0000_0000_0000 && b == ONES) r = a;
               else r = sA / sB;
      OP_DIVU: r = (uB == 0) ? ONES : uA / uB;
      OP_REM:  if (sB == 0) r = sA;
               else if (!ew && a == 64'h8000_0000_0000_0000 && b == ONES) r = '0;
               else r = sA % sB;
      OP_REMU: r = (uB == 0) ? uA : uA % uB;
      default: r = '0;
    endcase
    if (ew) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  function automatic int refLatency(input logic [2:0] o, input logic wf,
                                    input logic [63:0] a, input logic [63:0] b);
    logic ew, zero, ovf;
    ew   = effectiveW(o, wf);
    zero = ew ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf  = (o == OP_DIV || o == OP_REM) &&
           (ew ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
               : (a == 64'h8000_0000_0000_0000 && b == ONES));
    if (o[2] && (zero || ovf)) return 2;
    return ew ? 33 : 65;
  endfunction

  // Offers one op, scrambles the inputs after the accepting edge, and waits for out_valid.
  task automatic applyStimulus(input logic [2:0] o, input logic wf, input logic [63:0] a,
                               input logic [63:0] b, input logic [4:0] t,
                               output logic [63:0] res, output logic [4:0] tg, output int lat);
    @(negedge clk);
    op = o; w = wf; op1 = a; op2 = b; tagIn = t; inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom};
    tagIn = 5'($urandom); op = 3'($urandom); w = 1'($urandom);
    lat = 0;
    while (lat < 200 && !outValid) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
    tg  = tagOut;
  endtask

  task automatic consume();
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
  endtask

  task automatic runChecked(input string name, input logic [2:0] o, input logic wf,
                            input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                            input int expLat, input logic [4:0] t);
    logic [63:0] res;
    logic [4:0]  tg;
    int          lat;
    applyStimulus(o, wf, a, b, t, res, tg, lat);
    checkOutput(name, res, exp);
    checkOutput({name, "_latency"}, 64'(lat), 64'(expLat));
    checkOutput({name, "_tag"}, 64'(tg), 64'(t));
    consume();
  endtask

  initial begin
    logic [63:0] res, a, b;
    logic [4:0]  tg;
    logic [2:0]  o;
    logic        wf;
    int          lat, sawValid;

    rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    op = '0; w = 1'b0; op1 = '0; op2 = '0; tagIn = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 64'(inReady), 64'd1);
    checkOutput("reset_out_valid", 64'(outValid), 64'd0);
    checkOutput("reset_result", result, 64'd0);
    checkOutput("reset_tag", 64'(tagOut), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{OP_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, "mul_7_m3"});
    vecs.push_back('{OP_MULHU, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu_ones"});
    vecs.push_back('{OP_MULH, 1'b0, ONES, ONES, 64'd0, 65, "mulh_ones"});
    vecs.push_back('{OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_m7_2"});
    vecs.push_back('{OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65, "rem_m7_2"});
    vecs.push_back('{OP_DIVU, 1'b0, 64'd5, 64'd0, ONES, 2, "divu_by_zero"});
    vecs.push_back('{OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 2, "remu_by_zero"});
    vecs.push_back('{OP_DIV, 1'b1, 64'h0000_0000_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 2, "divw_overflow"});
    vecs.push_back('{OP_REM, 1'b1, 64'h0000_0000_8000_0000, ONES, 64'd0, 2, "remw_overflow"});
    vecs.push_back('{OP_DIV, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 2, "div_overflow"});
    vecs.push_back('{OP_REM, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'd0, 2, "rem_overflow"});
    vecs.push_back('{OP_MUL, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, "mulw_wrap"});
    vecs.push_back('{OP_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33, "divuw"});
    vecs.push_back('{OP_REMU, 1'b1, 64'h0000_0001_0000_0007, 64'd5, 64'd2, 33, "remuw_low_bits"});
    vecs.push_back('{OP_DIV, 1'b1, 64'd5, 64'h0000_0001_0000_0000, ONES, 2, "divw_by_zero_low"});
    vecs.push_back('{OP_MULHSU, 1'b1, ONES, 64'd2, ONES, 65, "mulhsu_w_ignored"});
    vecs.push_back('{OP_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, ONES, 33, "remw_neg"});
    vecs.push_back('{OP_DIV, 1'b1, 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 33, "divw_upper_junk"});

    foreach (vecs[i])
      runChecked(vecs[i].name, vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b,
                 vecs[i].exp, vecs[i].lat, 5'(i + 3));

    // Backpressure: result held stable for 10 cycles, then drained by a single out_ready pulse.
    applyStimulus(OP_DIV, 1'b0, 64'd100, 64'd7, 5'd9, res, tg, lat);
    checkOutput("stall_first", res, 64'd14);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_valid", 64'(outValid), 64'd1);
      checkOutput("stall_result", result, 64'd14);
      checkOutput("stall_in_ready", 64'(inReady), 64'd0);
    end
    checkOutput("stall_tag", 64'(tagOut), 64'd9);
    consume();
    checkOutput("drain_out_valid", 64'(outValid), 64'd0);
    checkOutput("drain_in_ready", 64'(inReady), 64'd1);

    // Consume and a new offer in the same DONE cycle: only the consume takes effect.
    applyStimulus(OP_MULHU, 1'b0, 64'd3, 64'd4, 5'd1, res, tg, lat);
    @(negedge clk);
    outReady = 1'b1; inValid = 1'b1; op = OP_MUL; op1 = 64'd3; op2 = 64'd4;
    @(posedge clk);
    #1;
    outReady = 1'b0; inValid = 1'b0;
    checkOutput("same_cycle_out_valid", 64'(outValid), 64'd0);
    checkOutput("same_cycle_not_accepted", 64'(inReady), 64'd1);
    runChecked("accept_after_consume", OP_MUL, 1'b0, 64'd3, 64'd4, 64'd12, 65, 5'd2);

    // Abort mid-operation, first with flush then with rst.
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      op = OP_MUL; w = 1'b0; op1 = 64'd11; op2 = 64'd13; tagIn = 5'd4; inValid = 1'b1;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      repeat (21) @(posedge clk);
      @(negedge clk);
      if (pass == 0) flush = 1'b1; else rst = 1'b1;
      inValid = 1'b1; op = OP_DIVU; op1 = 64'd50; op2 = 64'd5;
      @(posedge clk);
      #1;
      flush = 1'b0; rst = 1'b0; inValid = 1'b0;
      checkOutput(pass == 0 ? "flush_in_ready" : "rst_in_ready", 64'(inReady), 64'd1);
      checkOutput(pass == 0 ? "flush_out_valid" : "rst_out_valid", 64'(outValid), 64'd0);
      sawValid = 0;
      for (int k = 0; k < 70; k++) begin
        @(posedge clk);
        #1;
        if (outValid) sawValid++;
      end
      checkOutput(pass == 0 ? "flush_no_result" : "rst_no_result", 64'(sawValid), 64'd0);
      runChecked(pass == 0 ? "after_flush" : "after_rst", OP_MUL, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFF6, 64'd6, 64'hFFFF_FFFF_FFFF_FFC4, 65, 5'd17);
    end

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      o  = 3'($urandom);
      wf = 1'($urandom);
      a  = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       b = 64'd0;
        1:       b = ONES;
        2:       b = 64'($urandom_range(1, 300));
        3:       b = {$urandom, 32'd0};
        default: b = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 5) == 0) a = wf ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
      runChecked($sformatf("rand%0d_op%0d_w%0d", n, o, wf), o, wf, a, b,
                 refModel(o, wf, a, b), refLatency(o, wf, a, b), 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
